// File: rtl/nasti_dma_pkg.sv
// Shared types for the multi-channel NASTI DMA controller: channel/engine
// states and the latched descriptor record.
package nasti_dma_pkg;

    localparam int DESC_AW = 64;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACTIVE
    } chan_state_t;

    typedef enum logic [1:0] {
        FREE,
        ISSUE,
        RUN
    } eng_state_t;

    typedef struct packed {
        logic [DESC_AW-1:0] from;
        logic [DESC_AW-1:0] to;
        logic [DESC_AW-1:0] len;
        logic               dir;
    } dma_desc_t;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin picker over N request lines; the search starts one past the
// last accepted grant, and the pointer only moves when the grant is taken.
module dma_rr_arbiter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [CW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [CW-1:0] ptr;
    logic [CW-1:0] idx;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr <= CW'(N - 1);
        end else if (advance && gnt_valid) begin
            ptr <= gnt_idx;
        end
    end

    // Offset 1..N from the pointer, so the last winner is checked last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = 1; i <= N; i++) begin
            idx = CW'((int'(ptr) + i) % N);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/nasti_dma_mc_ctrlr.sv
// Multi-channel DMA controller: NCHAN descriptor slots dispatched round-robin
// onto engine A (a->b) and engine B (b->a). Optional NASTI_DMA_LEN_CHECK_EN.
module nasti_dma_mc_ctrlr
    import nasti_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int NCHAN      = 4,
    parameter int CW         = $clog2(NCHAN)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cpu_en,
    input  logic [CW-1:0]         cpu_chan,
    input  logic                  direction,
    input  logic [ADDR_WIDTH-1:0] from_addr,
    input  logic [ADDR_WIDTH-1:0] to_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic                  cpu_rej,
    output logic [NCHAN-1:0]      busy,
    output logic [NCHAN-1:0]      done,
    output logic [NCHAN-1:0]      err,
    input  logic [NCHAN-1:0]      done_clr,
    output logic                  irq,
    output logic                  dm_valid_a,
    input  logic                  dm_ready_a,
    output logic [ADDR_WIDTH-1:0] dm_from_a,
    output logic [ADDR_WIDTH-1:0] dm_to_a,
    output logic [ADDR_WIDTH-1:0] dm_len_a,
    input  logic                  dm_done_a,
    output logic                  dm_valid_b,
    input  logic                  dm_ready_b,
    output logic [ADDR_WIDTH-1:0] dm_from_b,
    output logic [ADDR_WIDTH-1:0] dm_to_b,
    output logic [ADDR_WIDTH-1:0] dm_len_b,
    input  logic                  dm_done_b
);

    chan_state_t           ch_state   [NCHAN];
    chan_state_t           ch_state_n [NCHAN];
    dma_desc_t             ch_desc    [NCHAN];
    dma_desc_t             ch_desc_n  [NCHAN];

    eng_state_t            eng_state   [2];
    eng_state_t            eng_state_n [2];
    logic [CW-1:0]         owner       [2];
    logic [CW-1:0]         owner_n     [2];
    logic [ADDR_WIDTH-1:0] eng_from    [2];
    logic [ADDR_WIDTH-1:0] eng_from_n  [2];
    logic [ADDR_WIDTH-1:0] eng_to      [2];
    logic [ADDR_WIDTH-1:0] eng_to_n    [2];
    logic [ADDR_WIDTH-1:0] eng_len     [2];
    logic [ADDR_WIDTH-1:0] eng_len_n   [2];

    logic [NCHAN-1:0]      req       [2];
    logic [CW-1:0]         gnt_idx   [2];
    logic [1:0]            gnt_valid;
    logic [1:0]            advance;
    logic [1:0]            eng_ready;
    logic [1:0]            eng_done;

    logic [NCHAN-1:0]      done_q;
    logic [NCHAN-1:0]      done_set;
    logic                  rej_q;
    logic                  rej_n;
    logic                  irq_q;
    logic                  chan_ok;
    dma_desc_t             wr_desc;

    assign eng_ready = {dm_ready_b, dm_ready_a};
    assign eng_done  = {dm_done_b, dm_done_a};
    assign chan_ok   = int'(cpu_chan) < NCHAN;
    assign wr_desc   = '{from: DESC_AW'(from_addr), to: DESC_AW'(to_addr),
                         len: DESC_AW'(length), dir: direction};

`ifdef NASTI_DMA_LEN_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

    logic [NCHAN-1:0] err_q;
    logic [NCHAN-1:0] err_set;
    logic             desc_bad;

    assign desc_bad = (length == '0) || ((from_addr & ALIGN_MASK) != '0) ||
                      ((to_addr & ALIGN_MASK) != '0) || ((length & ALIGN_MASK) != '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= '0;
        end else begin
            err_q <= (err_q & ~done_clr) | err_set;
        end
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

    // Engine A serves direction 0 and engine B direction 1, so the two
    // request vectors are disjoint and both engines may grant together.
    always_comb begin
        req[0]  = '0;
        req[1]  = '0;
        advance = '0;
        for (int c = 0; c < NCHAN; c++) begin
            req[0][c] = (ch_state[c] == PEND) && !ch_desc[c].dir;
            req[1][c] = (ch_state[c] == PEND) &&  ch_desc[c].dir;
            busy[c]   = ch_state[c] != IDLE;
        end
        for (int e = 0; e < 2; e++) begin
            advance[e] = (eng_state[e] == FREE) && gnt_valid[e];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_arb
        dma_rr_arbiter #(.N(NCHAN), .CW(CW)) u_arb (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .req       (req[g]),
            .advance   (advance[g]),
            .gnt_idx   (gnt_idx[g]),
            .gnt_valid (gnt_valid[g])
        );
    end

    always_comb begin
        ch_state_n  = ch_state;
        ch_desc_n   = ch_desc;
        eng_state_n = eng_state;
        owner_n     = owner;
        eng_from_n  = eng_from;
        eng_to_n    = eng_to;
        eng_len_n   = eng_len;
        done_set    = '0;
        rej_n       = 1'b0;
`ifdef NASTI_DMA_LEN_CHECK_EN
        err_set     = '0;
`endif

        if (cpu_en) begin
            if (!chan_ok) begin
                rej_n = 1'b1;
            end else if (ch_state[cpu_chan] != IDLE) begin
                rej_n = 1'b1;
`ifdef NASTI_DMA_LEN_CHECK_EN
            end else if (desc_bad) begin
                err_set[cpu_chan] = 1'b1;
`endif
            end else begin
                ch_state_n[cpu_chan] = PEND;
                ch_desc_n[cpu_chan]  = wr_desc;
            end
        end

        // Only the channel states touched by each branch differ, so the
        // write path and both engines never fight over one slot.
        for (int e = 0; e < 2; e++) begin
            case (eng_state[e])
                FREE: begin
                    if (gnt_valid[e]) begin
                        eng_state_n[e]         = ISSUE;
                        owner_n[e]             = gnt_idx[e];
                        ch_state_n[gnt_idx[e]] = ACTIVE;
                        eng_from_n[e]          = ADDR_WIDTH'(ch_desc[gnt_idx[e]].from);
                        eng_to_n[e]            = ADDR_WIDTH'(ch_desc[gnt_idx[e]].to);
                        eng_len_n[e]           = ADDR_WIDTH'(ch_desc[gnt_idx[e]].len);
                    end
                end
                ISSUE: begin
                    if (eng_ready[e]) begin
                        eng_state_n[e] = RUN;
                    end
                end
                RUN: begin
                    if (eng_done[e]) begin
                        eng_state_n[e]       = FREE;
                        ch_state_n[owner[e]] = IDLE;
                        done_set[owner[e]]   = 1'b1;
                    end
                end
                default: eng_state_n[e] = FREE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int c = 0; c < NCHAN; c++) begin
                ch_state[c] <= IDLE;
                ch_desc[c]  <= '0;
            end
            for (int e = 0; e < 2; e++) begin
                eng_state[e] <= FREE;
                owner[e]     <= '0;
                eng_from[e]  <= '0;
                eng_to[e]    <= '0;
                eng_len[e]   <= '0;
            end
            done_q <= '0;
            rej_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            ch_state  <= ch_state_n;
            ch_desc   <= ch_desc_n;
            eng_state <= eng_state_n;
            owner     <= owner_n;
            eng_from  <= eng_from_n;
            eng_to    <= eng_to_n;
            eng_len   <= eng_len_n;
            done_q    <= (done_q & ~done_clr) | done_set;
            rej_q     <= rej_n;
            irq_q     <= |(done_q | err);
        end
    end

    assign done       = done_q;
    assign cpu_rej    = rej_q;
    assign irq        = irq_q;
    assign dm_valid_a = eng_state[0] == ISSUE;
    assign dm_from_a  = eng_from[0];
    assign dm_to_a    = eng_to[0];
    assign dm_len_a   = eng_len[0];
    assign dm_valid_b = eng_state[1] == ISSUE;
    assign dm_from_b  = eng_from[1];
    assign dm_to_b    = eng_to[1];
    assign dm_len_b   = eng_len[1];

endmodule

// File: tb/tb_nasti_dma_mc_ctrlr.sv
// Directed bench for nasti_dma_mc_ctrlr; the length-check section follows
// NASTI_DMA_LEN_CHECK_EN the same way the RTL does.
module tb_nasti_dma_mc_ctrlr;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cpu_en;
    logic [1:0]  cpu_chan;
    logic        direction;
    logic [63:0] from_addr, to_addr, length;
    logic        cpu_rej;
    logic [3:0]  busy, done, err, done_clr;
    logic        irq;
    logic        dm_valid_a, dm_ready_a, dm_done_a;
    logic [63:0] dm_from_a, dm_to_a, dm_len_a;
    logic        dm_valid_b, dm_ready_b, dm_done_b;
    logic [63:0] dm_from_b, dm_to_b, dm_len_b;

    int vectors = 0;
    int miscompares = 0;

    nasti_dma_mc_ctrlr #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .NCHAN(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .cpu_en(cpu_en), .cpu_chan(cpu_chan),
        .direction(direction), .from_addr(from_addr), .to_addr(to_addr), .length(length),
        .cpu_rej(cpu_rej), .busy(busy), .done(done), .err(err), .done_clr(done_clr), .irq(irq),
        .dm_valid_a(dm_valid_a), .dm_ready_a(dm_ready_a), .dm_from_a(dm_from_a),
        .dm_to_a(dm_to_a), .dm_len_a(dm_len_a), .dm_done_a(dm_done_a),
        .dm_valid_b(dm_valid_b), .dm_ready_b(dm_ready_b), .dm_from_b(dm_from_b),
        .dm_to_b(dm_to_b), .dm_len_b(dm_len_b), .dm_done_b(dm_done_b)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle descriptor write; returns just after the sampling edge.
    task automatic apply_stimulus(input logic [1:0] ch, input logic dir,
                                  input logic [63:0] f, input logic [63:0] t, input logic [63:0] l);
        cpu_en = 1'b1; cpu_chan = ch; direction = dir;
        from_addr = f; to_addr = t; length = l;
        tick();
        cpu_en = 1'b0;
    endtask

    task automatic wait_valid(input int eng);
        int n = 0;
        while (((eng == 0) ? dm_valid_a : dm_valid_b) !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        check_output("dispatch_wait", (eng == 0) ? dm_valid_a : dm_valid_b, 1);
    endtask

    task automatic handshake_a();
        dm_ready_a = 1'b1; tick(); dm_ready_a = 1'b0;
    endtask

    task automatic complete_a();
        dm_done_a = 1'b1; tick(); dm_done_a = 1'b0;
    endtask

    task automatic clear_all();
        done_clr = 4'hF; tick(); done_clr = 4'h0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          exp_ch   [6] = '{0, 1, 2, 3, 0, 2};
        logic [63:0] exp_from [6] = '{64'h10000, 64'h10100, 64'h10200, 64'h10300, 64'h30000, 64'h30200};

        aresetn = 1'b0; cpu_en = 1'b0; cpu_chan = '0; direction = 1'b0;
        from_addr = '0; to_addr = '0; length = '0; done_clr = '0;
        dm_ready_a = 1'b0; dm_done_a = 1'b0; dm_ready_b = 1'b0; dm_done_b = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err", err, 0);
        check_output("rst_irq", irq, 0);
        check_output("rst_rej", cpu_rej, 0);
        check_output("rst_valid_a", dm_valid_a, 0);
        check_output("rst_valid_b", dm_valid_b, 0);
        check_output("rst_from_a", dm_from_a, 0);
        check_output("rst_len_b", dm_len_b, 0);
        aresetn = 1'b1;
        tick();

        $display("[TB] single transfer");
        apply_stimulus(2'd0, 1'b0, 64'h1000, 64'h2000, 64'h40);
        check_output("t1_busy", busy, 4'b0001);
        check_output("t1_valid_early", dm_valid_a, 0);
        tick();
        check_output("t1_valid", dm_valid_a, 1);
        check_output("t1_from", dm_from_a, 64'h1000);
        check_output("t1_to", dm_to_a, 64'h2000);
        check_output("t1_len", dm_len_a, 64'h40);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t1_hold_valid", dm_valid_a, 1);
            check_output("t1_hold_from", dm_from_a, 64'h1000);
            check_output("t1_hold_len", dm_len_a, 64'h40);
        end
        handshake_a();
        check_output("t1_valid_after_hs", dm_valid_a, 0);
        check_output("t1_busy_run", busy, 4'b0001);
        complete_a();
        check_output("t1_done", done, 4'b0001);
        check_output("t1_busy_clr", busy, 4'b0000);
        check_output("t1_irq_lag", irq, 0);
        tick();
        check_output("t1_irq", irq, 1);
        done_clr = 4'b0001; tick(); done_clr = 4'b0000;
        check_output("t1_done_clr", done, 0);
        tick();
        check_output("t1_irq_clr", irq, 0);

        $display("[TB] round robin");
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(2'(c), 1'b0, 64'h10000 + 64'(c) * 64'h100, 64'h20000, 64'h40);
        end
        for (int k = 0; k < 6; k++) begin
            wait_valid(0);
            check_output("rr_order", dm_from_a, exp_from[k]);
            handshake_a();
            if (k == 3) begin
                apply_stimulus(2'd2, 1'b0, 64'h30200, 64'h40000, 64'h40);
                apply_stimulus(2'd0, 1'b0, 64'h30000, 64'h40000, 64'h40);
                repeat (2) tick();
            end else begin
                repeat (4) tick();
            end
            complete_a();
            check_output("rr_chan_idle", busy[exp_ch[k]], 0);
            if (k == 3) check_output("rr_done_all", done, 4'b1111);
        end
        clear_all();

        $display("[TB] dual engine");
        apply_stimulus(2'd1, 1'b0, 64'h3000, 64'h3100, 64'h80);
        apply_stimulus(2'd2, 1'b1, 64'h4000, 64'h4100, 64'hC0);
        check_output("de_valid_a_first", dm_valid_a, 1);
        check_output("de_valid_b_first", dm_valid_b, 0);
        tick();
        check_output("de_overlap", {dm_valid_a, dm_valid_b}, 2'b11);
        check_output("de_from_a", dm_from_a, 64'h3000);
        check_output("de_from_b", dm_from_b, 64'h4000);
        check_output("de_len_b", dm_len_b, 64'hC0);
        dm_ready_a = 1'b1; dm_ready_b = 1'b1; tick(); dm_ready_a = 1'b0; dm_ready_b = 1'b0;
        check_output("de_busy", busy, 4'b0110);
        tick();
        dm_done_b = 1'b1; tick(); dm_done_b = 1'b0;
        check_output("de_done_b", done, 4'b0100);
        check_output("de_busy_b", busy, 4'b0010);
        tick();
        complete_a();
        check_output("de_done_both", done, 4'b0110);
        check_output("de_busy_none", busy, 4'b0000);
        clear_all();

        $display("[TB] busy write");
        apply_stimulus(2'd0, 1'b0, 64'h5000, 64'h6000, 64'h80);
        wait_valid(0);
        handshake_a();
        apply_stimulus(2'd0, 1'b0, 64'h7000, 64'h7100, 64'h100);
        check_output("bw_rej", cpu_rej, 1);
        check_output("bw_from_kept", dm_from_a, 64'h5000);
        tick();
        check_output("bw_rej_pulse", cpu_rej, 0);
        cpu_en = 1'b1; cpu_chan = 2'd0; from_addr = 64'h7000; dm_done_a = 1'b1;
        check_output("bw_done_payload", dm_from_a, 64'h5000);
        check_output("bw_done_len", dm_len_a, 64'h80);
        tick();
        cpu_en = 1'b0; dm_done_a = 1'b0;
        check_output("bw_same_cycle_rej", cpu_rej, 1);
        check_output("bw_done", done[0], 1);
        check_output("bw_busy", busy, 4'b0000);
        tick();
        check_output("bw_no_dispatch", dm_valid_a, 0);

        $display("[TB] reset mid-run");
        apply_stimulus(2'd3, 1'b0, 64'h8000, 64'h8100, 64'h40);
        wait_valid(0);
        handshake_a();
        apply_stimulus(2'd1, 1'b1, 64'h9000, 64'h9100, 64'h40);
        tick();
        check_output("rr_pre_valid_b", dm_valid_b, 1);
        #2 aresetn = 1'b0;
        #1;
        check_output("mr_valid_b", dm_valid_b, 0);
        check_output("mr_busy", busy, 0);
        check_output("mr_done", done, 0);
        check_output("mr_irq", irq, 0);
        check_output("mr_from_a", dm_from_a, 0);
        check_output("mr_from_b", dm_from_b, 0);
        #2 aresetn = 1'b1;
        tick();
        complete_a();
        check_output("mr_late_done", done, 0);
        check_output("mr_late_busy", busy, 0);
        check_output("mr_late_valid", dm_valid_a, 0);
        apply_stimulus(2'd0, 1'b0, 64'hA000, 64'hB000, 64'h40);
        wait_valid(0);
        check_output("mr_redispatch", dm_from_a, 64'hA000);
        handshake_a();
        dm_done_a = 1'b1; done_clr = 4'b0001; tick(); dm_done_a = 1'b0; done_clr = 4'b0000;
        check_output("clr_overlap", done, 4'b0001);
        tick();
        check_output("clr_overlap_irq", irq, 1);
        clear_all();

        $display("[TB] length check");
`ifdef NASTI_DMA_LEN_CHECK_EN
        apply_stimulus(2'd1, 1'b0, 64'h1000, 64'h2000, 64'h0);
        check_output("lc_len0_err", err, 4'b0010);
        check_output("lc_len0_busy", busy, 0);
        check_output("lc_len0_rej", cpu_rej, 0);
        repeat (2) tick();
        check_output("lc_len0_valid", dm_valid_a, 0);
        clear_all();
        check_output("lc_err_clr", err, 0);
        apply_stimulus(2'd1, 1'b0, 64'h1004, 64'h2000, 64'h40);
        check_output("lc_align_err", err, 4'b0010);
        check_output("lc_align_busy", busy, 0);
        repeat (2) tick();
        check_output("lc_align_valid", dm_valid_a, 0);
`else
        apply_stimulus(2'd1, 1'b0, 64'h1004, 64'h2000, 64'h40);
        check_output("lc_off_busy", busy, 4'b0010);
        check_output("lc_off_err", err, 0);
        wait_valid(0);
        check_output("lc_off_from", dm_from_a, 64'h1004);
        handshake_a();
        complete_a();
        check_output("lc_off_done", done, 4'b0010);
        check_output("lc_off_err_after", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nasti_dma_mc_ctrlr.md
# nasti_dma_mc_ctrlr

Multi-channel successor to the single-descriptor DMA controller. It accepts transfer descriptors from the CPU into NCHAN independent channel slots. Pending channels are arbitrated round-robin onto two datamover engines: engine A moves a->b, engine B moves b->a. Per-channel busy, done and error status plus a combined interrupt are reported back to the CPU. The block sits between the CPU register file and the two NASTI datamovers.

## Interface
Parameters:
- ADDR_WIDTH, 64, width of addresses and length
- DATA_WIDTH, 64, datamover beat width; alignment unit is DATA_WIDTH/8 bytes
- NCHAN, 4, number of channel slots (2..16)
- CW, $clog2(NCHAN), width of the channel index

Ports:
- aclk  in  1  clock, all logic on the rising edge
- aresetn  in  1  reset, asynchronous, active-low
- cpu_en  in  1  one-cycle descriptor write strobe
- cpu_chan  in  CW  target channel of the write
- direction  in  1  0: a->b (engine A), 1: b->a (engine B)
- from_addr, to_addr, length  in  ADDR_WIDTH each  descriptor fields
- cpu_rej  out  1  registered pulse; the write was dropped because the channel was busy
- busy  out  NCHAN  channel is PEND or ACTIVE
- done  out  NCHAN  sticky completion flags
- err  out  NCHAN  sticky error flags (see Configuration)
- done_clr  in  NCHAN  write-1-to-clear for done and err
- irq  out  1  registered |(done|err)
- dm_valid_x  out  1  dispatch request to engine x (x = a, b)
- dm_ready_x  in  1  engine accepts the request
- dm_from_x, dm_to_x, dm_len_x  out  ADDR_WIDTH  dispatched descriptor
- dm_done_x  in  1  one-cycle pulse: the engine finished its current transfer

## Operation
- Per-channel state: IDLE -> PEND -> ACTIVE -> IDLE. The state holds the latched descriptor and its direction.
- Descriptor write:
  - cpu_en to an IDLE channel latches the descriptor; the channel moves to PEND.
  - cpu_en to a PEND or ACTIVE channel is ignored, and cpu_rej pulses the next cycle.
  - cpu_chan >= NCHAN is ignored with cpu_rej.
- Engine state: FREE, ISSUE, RUN. Each engine also holds an owner register of CW bits.
- Dispatch: an engine in FREE grants one PEND channel whose direction matches the engine. The winner is chosen round-robin, and priority starts at last_grant+1 modulo NCHAN. On a grant:
  - the engine moves to ISSUE and loads dm_* from the descriptor;
  - owner is set to the winner; the channel moves to ACTIVE.
- ISSUE: dm_valid_x=1 with a stable payload until dm_ready_x=1. After that handshake the engine is in RUN.
- RUN: when dm_done_x arrives, the owner channel moves to IDLE and its done bit is set; the engine returns to FREE.
- dm_done_x while the engine is FREE or ISSUE is ignored.
- done/err bits:
  - set on the completion edge and cleared by done_clr;
  - a simultaneous set and clear leaves the bit set;
  - a new descriptor does not clear them.
- Length arithmetic is pass-through with no modification. The address/length payload must not change while ACTIVE.

## Timing
- Reset values:
  - all channels IDLE; both engines FREE;
  - dm_valid_x, cpu_rej, irq = 0; busy, done, err = 0;
  - dm_* payloads = 0; both round-robin pointers = NCHAN-1, so channel 0 has first priority.
- cpu_en at edge t: busy goes high at t+1. The earliest grant is at t+1, with dm_valid_x high at t+2.
- A dm_valid/dm_ready handshake at edge t puts the engine in RUN from t+1.
- dm_done_x at edge t: busy and the ACTIVE state drop and done sets at t+1; irq rises at t+2. The engine is FREE at t+1 and can grant at t+1, so dm_valid_x is again high at t+2.
- Same-cycle cpu_en and dm_done for the same channel: the channel is still busy that cycle, so the write is rejected.
- Both engines may grant in the same cycle; they never contend for the same channel because the two engines match opposite directions.
- Asserting aresetn low mid-transfer:
  - all state clears immediately and dm_valid_x drops asynchronously;
  - the in-flight engine transfer is abandoned;
  - any dm_done pulse arriving after reset is ignored because the engine is FREE.

## Configuration
- NASTI_DMA_LEN_CHECK_EN defined:
  - on cpu_en to an IDLE channel, the descriptor is checked;
  - it is rejected when length==0 or any of from_addr/to_addr/length is not a multiple of DATA_WIDTH/8;
  - a rejected descriptor sets err for the channel at t+1, the channel stays IDLE, and nothing is dispatched.
- Undefined: no check is done, every descriptor is dispatched, and err is tied to 0.

## Structure
- Package nasti_dma_pkg holds:
  - chan_state_t {IDLE, PEND, ACTIVE} and eng_state_t {FREE, ISSUE, RUN};
  - the packed struct dma_desc_t {from, to, len, dir}.
- One sub-module, dma_rr_arbiter (params N, CW; request vector in, grant index plus grant-valid out, pointer register inside). It is instantiated once per engine.

## Test plan
- Single transfer: write ch0, dir=0, from=0x1000, to=0x2000, len=0x40.
  - dm_valid_a at t+2 with the same payload; hold ready low 3 cycles, payload stays stable.
  - dm_done_a at edge t: done[0]=1 and busy[0]=0 at t+1, irq=1 at t+2.
- Round-robin: ch0..ch3 all dir=0, ready=1, with done 5 cycles after each handshake.
  - Dispatch order is 0,1,2,3.
  - Re-queuing ch0 and ch2 with the pointer at 3 gives 0 then 2.
- Dual engine: ch1 dir=0 and ch2 dir=1 written back-to-back. dm_valid_a and dm_valid_b overlap, and the two completions are tracked independently.
- Busy write: write ch0 while it is ACTIVE. cpu_rej pulses, the descriptor is unchanged, and the later completion reports the original payload.
- Reset mid-RUN: drop aresetn, then pulse dm_done_a after release.
  - All outputs are at their reset values and done stays 0.
  - A done_clr that overlaps a done set leaves done=1.
- With NASTI_DMA_LEN_CHECK_EN: len=0 or from=0x1004 sets err=1, there is no dm_valid, and busy stays 0. Without the macro the same descriptor is dispatched.
